// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the unified-memory port arbiter.
package mem_port_arbiter_pkg;

  localparam int unsigned ArbAddrW = 32;
  localparam int unsigned ArbDataW = 32;
  localparam int unsigned ArbBeW   = ArbDataW / 8;

  typedef logic [ArbDataW-1:0] word_t;

  typedef enum logic {StIdle, StWait} arb_state_e;
  typedef enum logic {OwnInstr, OwnData} arb_owner_e;

  // Registered command presented to the memory.
  typedef struct packed {
    logic                we;
    logic [ArbBeW-1:0]   be;
    logic [ArbAddrW-1:0] addr;
    word_t               wdata;
  } mem_cmd_t;

  // Fetches are full-word reads.
  function automatic mem_cmd_t fetch_cmd(input logic [ArbAddrW-1:0] addr);
    mem_cmd_t cmd;
    cmd.we    = 1'b0;
    cmd.be    = '1;
    cmd.addr  = addr;
    cmd.wdata = '0;
    return cmd;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Signal bundle between the core's fetch/data ports, the arbiter and the unified memory.
interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_W = mem_port_arbiter_pkg::ArbAddrW,
  parameter int unsigned DATA_W = mem_port_arbiter_pkg::ArbDataW
) ();

  logic                  if_req;
  logic [ADDR_W-1:0]     if_addr;
  logic                  if_gnt;
  logic                  if_rvalid;
  logic [DATA_W-1:0]     if_rdata;

  logic                  d_req;
  logic                  d_we;
  logic [DATA_W/8-1:0]   d_be;
  logic [ADDR_W-1:0]     d_addr;
  logic [DATA_W-1:0]     d_wdata;
  logic                  d_gnt;
  logic                  d_rvalid;
  logic [DATA_W-1:0]     d_rdata;

  logic                  mem_req;
  logic                  mem_we;
  logic [DATA_W/8-1:0]   mem_be;
  logic [ADDR_W-1:0]     mem_addr;
  logic [DATA_W-1:0]     mem_wdata;
  logic [DATA_W-1:0]     mem_rdata;

  // Core requesters plus memory
  modport master (
    output if_req, if_addr, d_req, d_we, d_be, d_addr, d_wdata, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
    input  mem_req, mem_we, mem_be, mem_addr, mem_wdata
  );

  // Arbiter
  modport slave (
    input  if_req, if_addr, d_req, d_we, d_be, d_addr, d_wdata, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
    output mem_req, mem_we, mem_be, mem_addr, mem_wdata
  );

endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency single-port memory between fetch and data ports. One access in
// flight; data has priority, fetch wins after MAX_STARVE consecutive losses.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W     = ArbAddrW,
  parameter int unsigned DATA_W     = ArbDataW,
  parameter int unsigned LATENCY    = 1,
  parameter int unsigned MAX_STARVE = 4
) (
  input logic               clock,
  input logic               reset,
  mem_port_arbiter_if.slave bus
);

  localparam logic [3:0] LatCnt    = 4'(LATENCY);
  localparam logic [3:0] StarveMax = 4'(MAX_STARVE);

  arb_state_e        state_q;
  arb_owner_e        owner_q;
  logic [3:0]        cnt_q;
  logic [3:0]        starve_q;
  mem_cmd_t          cmd_q;
  logic              mem_req_q;
  logic              if_gnt_q;
  logic              if_rvalid_q;
  logic              d_gnt_q;
  logic              d_rvalid_q;
  logic [DATA_W-1:0] if_rdata_q;
  logic [DATA_W-1:0] d_rdata_q;

  logic              if_wins;
  logic [ADDR_W-1:0] win_addr;
  mem_cmd_t          win_cmd;

  assign if_wins  = bus.if_req && (!bus.d_req || starve_q == StarveMax);
  assign win_addr = if_wins ? bus.if_addr : bus.d_addr;

  always_comb begin
    if (if_wins) begin
      win_cmd = fetch_cmd(win_addr);
    end else begin
      win_cmd = '{we: bus.d_we, be: bus.d_be, addr: win_addr, wdata: bus.d_wdata};
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= StIdle;
      owner_q     <= OwnData;
      cnt_q       <= '0;
      starve_q    <= '0;
      cmd_q       <= '0;
      mem_req_q   <= 1'b0;
      if_gnt_q    <= 1'b0;
      if_rvalid_q <= 1'b0;
      d_gnt_q     <= 1'b0;
      d_rvalid_q  <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
    end else begin
      mem_req_q   <= 1'b0;
      if_gnt_q    <= 1'b0;
      d_gnt_q     <= 1'b0;
      if_rvalid_q <= 1'b0;
      d_rvalid_q  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.if_req || bus.d_req) begin
            cmd_q     <= win_cmd;
            mem_req_q <= 1'b1;
            cnt_q     <= LatCnt;
            state_q   <= StWait;
            if (if_wins) begin
              if_gnt_q <= 1'b1;
              owner_q  <= OwnInstr;
              starve_q <= '0;
            end else begin
              d_gnt_q <= 1'b1;
              owner_q <= OwnData;
              // Count fetch losses only while a fetch is actually waiting.
              if (!bus.if_req) begin
                starve_q <= '0;
              end else if (starve_q != StarveMax) begin
                starve_q <= starve_q + 4'd1;
              end
            end
          end
        end
        StWait: begin
          if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end else begin
            state_q <= StIdle;
            if (owner_q == OwnInstr) begin
              if_rvalid_q <= 1'b1;
              if_rdata_q  <= bus.mem_rdata;
            end else begin
              d_rvalid_q <= 1'b1;
              d_rdata_q  <= cmd_q.we ? '0 : bus.mem_rdata;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = cmd_q.we;
  assign bus.mem_be    = cmd_q.be;
  assign bus.mem_addr  = cmd_q.addr;
  assign bus.mem_wdata = cmd_q.wdata;
  assign bus.if_gnt    = if_gnt_q;
  assign bus.if_rvalid = if_rvalid_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.d_gnt     = d_gnt_q;
  assign bus.d_rvalid  = d_rvalid_q;
  assign bus.d_rdata   = d_rdata_q;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port unified memory between the core's instruction-fetch port and its data load/store port.
- Sits between FloppyComp_V1 and the memory. It replaces the separate instruction and data memories with one memory of fixed read latency.
- Fixed priority: data over instruction, with a starvation guard for instruction.
- One access outstanding at a time. Every accepted request gets a one-cycle gnt and, later, a one-cycle rvalid.

Parameters:
- ADDR_W, 32, address width of both requester ports and the memory port.
- DATA_W, 32, data word width.
- LATENCY, 1, number of cycles from the mem_req cycle to the cycle mem_rdata is valid. Legal range 0..15.
- MAX_STARVE, 4, consecutive instruction losses allowed while if_req is held. Legal range 1..15.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- if_req  in  1  instruction read request; held stable until if_gnt
- if_addr  in  ADDR_W  instruction fetch address
- if_gnt  out  1  request accepted (pulse)
- if_rvalid  out  1  fetch data valid (pulse)
- if_rdata  out  DATA_W  fetch data
- d_req  in  1  data request; held stable until d_gnt
- d_we  in  1  1 = store, 0 = load
- d_be  in  DATA_W/8  byte enables for stores
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_gnt  out  1  request accepted (pulse)
- d_rvalid  out  1  load data valid, or store complete (pulse)
- d_rdata  out  DATA_W  load data; 0 for stores
- mem_req  out  1  memory access strobe (pulse)
- mem_we  out  1  memory write enable
- mem_be  out  DATA_W/8  memory byte enables
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid LATENCY cycles after the mem_req cycle

Behaviour:
- All outputs are registered.
- Reset values:
  - all gnt, rvalid and mem_req outputs = 0
  - all rdata, mem_addr, mem_wdata and mem_be = 0; mem_we = 0
  - state = IDLE, cnt = 0, starve_cnt = 0, owner = DATA
- FSM states: IDLE and WAIT.
- IDLE, at a clock edge with if_req or d_req high (accept edge E0):
  - Winner selection: INSTR wins if if_req && (!d_req || starve_cnt == MAX_STARVE); otherwise DATA wins.
  - Register the winner's command onto mem_*. For an INSTR access: mem_we = 0, mem_be = all ones, mem_wdata = 0.
  - Set mem_req = 1, winner gnt = 1, owner = winner, cnt = LATENCY, state = WAIT.
  - starve_cnt update:
    - INSTR wins: clear to 0.
    - DATA wins with if_req high: increment, saturating at MAX_STARVE.
    - DATA wins with if_req low: clear to 0.
- WAIT:
  - mem_req and gnt drop after their single cycle.
  - mem_we, mem_be, mem_addr and mem_wdata hold their values until the next accept.
  - Each edge with cnt != 0: decrement cnt.
  - Edge with cnt == 0:
    - Load owner rdata with mem_rdata, or with 0 if the access was a store.
    - Set owner rvalid = 1 for one cycle.
    - state = IDLE.
- Latency:
  - gnt is high in cycle C1, the cycle after E0.
  - rvalid is high in cycle C(LATENCY+2).
  - Peak throughput: one access per LATENCY+2 cycles.
- Back-to-back: the rvalid cycle is an IDLE cycle. A request sampled at the end of that cycle is accepted, so gnt never overlaps rvalid of the same port.
- Requests arriving while in WAIT are ignored. The requester keeps req asserted and is served later.
- Both requests arriving in the same IDLE cycle: resolved by the winner rule above; the loser stays pending.
- rdata holds its value after rvalid until the next rvalid to that port.
- Reset mid-access:
  - The outstanding access is dropped; no rvalid is issued for it.
  - All state returns to reset values on the next edge.
  - A memory write already strobed is not undone.
- Requester obligation: deassert req in the gnt cycle, or keep it asserted to request again.

Decomposition:
- Shared package (params.sv):
  - arb_state_e {IDLE, WAIT}
  - arb_owner_e {INSTR, DATA}
  - mem_cmd_t struct {we, be, addr, wdata}, reused for the registered mem_* bundle
- The word typedef is reused for DATA_W = 32.
- No sub-module is needed. Counters and FSM stay in one module, about 150–200 lines.

Test Plan:
- LATENCY=1, single load: d_req with d_addr=0x40, mem_rdata=0xDEADBEEF in C2 -> d_gnt in C1, mem_req in C1 with mem_addr=0x40, d_rvalid in C3 with d_rdata=0xDEADBEEF.
- Simultaneous requests: if_req with if_addr=0x0 and d_req with d_addr=0x80 in the same cycle -> DATA is granted first, INSTR is granted at the edge ending DATA's rvalid cycle, starve_cnt = 1 then 0.
- Starvation, MAX_STARVE=4: if_req held, d_req held continuously -> 4 data grants, then if_gnt on the 5th arbitration, then data resumes.
- Store, d_we=1, d_be=4'b0011, d_wdata=0x1234ABCD -> mem_we=1, mem_be=0011, d_rvalid asserted with d_rdata=0.
- LATENCY=0: fetch at 0x8, mem_rdata=0x00000013 in C1 -> if_rvalid in C2 with if_rdata=0x13.
- reset asserted in the WAIT cycle of a load -> no d_rvalid, all outputs 0 the next cycle, a new request after reset is served normally.
